ir_packet_receiver: RTL

//  Receive end of the car IR link: decodes demodulated IR packets (START, CAR_SELECT, RIGHT, LEFT, BACK, FORWARD bursts).
//  - Each burst is separated by a GAP.
//  - Produces a 4-bit COMMAND and a one-cycle CMD_VALID strobe.
//  - Sits between the IR photodiode/demodulator pin and the bus interface; used for loopback test and car-side logic.

---
 rtl/ir_pkg.sv | 67 ++++++
 rtl/ir_pulse_timer.sv | 43 ++++
 rtl/ir_packet_receiver.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the car IR link (receiver and transmitter).
// FSM encodings, field indices, command bit positions, per-car timing sets and length matching.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_GAP   = 3'd2,
    ST_BURST = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] FI_CAR_SELECT = 3'd1;
  localparam logic [2:0] FI_RIGHT      = 3'd2;
  localparam logic [2:0] FI_LEFT       = 3'd3;
  localparam logic [2:0] FI_BACK       = 3'd4;
  localparam logic [2:0] FI_FORWARD    = 3'd5;

  localparam logic [1:0] CMD_RIGHT   = 2'd0;
  localparam logic [1:0] CMD_LEFT    = 2'd1;
  localparam logic [1:0] CMD_BACK    = 2'd2;
  localparam logic [1:0] CMD_FORWARD = 2'd3;

  localparam logic [7:0] PERIOD_MAX = 8'd255;

  typedef struct packed {
    int unsigned clock_ratio;
    int unsigned start_burst;
    int unsigned car_select_burst;
    int unsigned gap;
    int unsigned assert_burst;
    int unsigned deassert_burst;
    int unsigned tolerance;
  } car_cfg_t;

  localparam car_cfg_t YELLOW_CAR = '{
    clock_ratio:      32'd1250,
    start_burst:      32'd88,
    car_select_burst: 32'd22,
    gap:              32'd40,
    assert_burst:     32'd44,
    deassert_burst:   32'd22,
    tolerance:        32'd4
  };

  function automatic logic len_match(input logic [7:0] len, input int unsigned size,
                                     input int unsigned tol);
    int l;
    int lo;
    int hi;
    l  = int'({24'd0, len});
    lo = int'(size) - int'(tol);
    hi = int'(size) + int'(tol);
    return (l >= lo) && (l <= hi);
  endfunction

  function automatic logic [1:0] field_bit(input logic [2:0] fi);
    case (fi)
      FI_RIGHT:   return CMD_RIGHT;
      FI_LEFT:    return CMD_LEFT;
      FI_BACK:    return CMD_BACK;
      FI_FORWARD: return CMD_FORWARD;
      default:    return CMD_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: carrier-period prescaler plus 8-bit saturating period counter.
// Both counters restart from zero whenever clr_i is asserted.
module ir_pulse_timer
  import ir_pkg::*;
#(
  parameter int unsigned ClockRatio = 1250,
  parameter int unsigned PrescW     = (ClockRatio > 1) ? $clog2(ClockRatio) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  output logic [PrescW-1:0] presc_o,
  output logic [7:0]        period_o,
  output logic              sat_o
);

  logic [PrescW-1:0] presc_q;
  logic [7:0]        period_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q  <= '0;
      period_q <= 8'd0;
    end else if (clr_i) begin
      presc_q  <= '0;
      period_q <= 8'd0;
    end else if (presc_q == PrescW'(ClockRatio - 1)) begin
      presc_q <= '0;
      if (period_q != PERIOD_MAX) begin
        period_q <= period_q + 8'd1;
      end else begin
        period_q <= period_q;
      end
    end else begin
      presc_q <= presc_q + PrescW'(1'b1);
    end
  end

  assign presc_o  = presc_q;
  assign period_o = period_q;
  assign sat_o    = (period_q == PERIOD_MAX);

endmodule

// File: rtl/ir_packet_receiver.sv
// ir_packet_receiver: decodes demodulated IR car-link packets into a 4-bit command strobe.
// Defining IR_RX_GLITCH_FILTER_EN inserts a FilterLen-cycle stability filter after the synchroniser.
module ir_packet_receiver
  import ir_pkg::*;
#(
  parameter int unsigned ClockRatio         = YELLOW_CAR.clock_ratio,
  parameter int unsigned StartBurstSize     = YELLOW_CAR.start_burst,
  parameter int unsigned CarSelectBurstSize = YELLOW_CAR.car_select_burst,
  parameter int unsigned GapSize            = YELLOW_CAR.gap,
  parameter int unsigned AsserBurstSize     = YELLOW_CAR.assert_burst,
  parameter int unsigned DeAsserBurstSize   = YELLOW_CAR.deassert_burst,
  parameter int unsigned Tolerance          = YELLOW_CAR.tolerance
`ifdef IR_RX_GLITCH_FILTER_EN
  , parameter int unsigned FilterLen        = 16
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       CMD_VALID,
  output logic       PKT_ERR,
  output logic [2:0] STATE
);

  localparam int unsigned PrescW = (ClockRatio > 1) ? $clog2(ClockRatio) : 1;

  logic [1:0]        sync_q;
  logic              level_s;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;
  logic [PrescW-1:0] presc_s;
  logic [7:0]        period_s;
  logic              sat_s;
  logic [7:0]        len_s;

  state_e            state_q;
  state_e            state_d;
  logic [2:0]        fi_q;
  logic [2:0]        fi_d;
  logic [3:0]        shadow_q;
  logic [3:0]        shadow_d;
  logic [3:0]        command_q;
  logic [3:0]        command_d;
  logic              cmd_valid_q;
  logic              cmd_valid_d;
  logic              pkt_err_q;
  logic              pkt_err_d;
  logic              abort_s;
  logic              bit_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], IR_IN};
    end
  end

`ifdef IR_RX_GLITCH_FILTER_EN
  localparam int unsigned FiltW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

  logic             filt_q;
  logic [FiltW-1:0] filt_cnt_q;

  // Level only follows the synchroniser after FilterLen consecutive disagreeing cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else if (sync_q[1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FiltW'(FilterLen - 1)) begin
      filt_q     <= sync_q[1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FiltW'(1'b1);
    end
  end

  assign level_s = filt_q;
`else
  assign level_s = sync_q[1];
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= level_s;
      rise_q <= level_s & ~prev_q;
      fall_q <= ~level_s & prev_q;
    end
  end

  ir_pulse_timer #(
    .ClockRatio(ClockRatio),
    .PrescW    (PrescW)
  ) u_timer (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (rise_q | fall_q),
    .presc_o (presc_s),
    .period_o(period_s),
    .sat_o   (sat_s)
  );

  // The edge is seen one cycle before the final wrap, so round the partial period.
  assign len_s = (!sat_s && (presc_s >= PrescW'(ClockRatio / 2))) ? (period_s + 8'd1) : period_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      fi_q     <= 3'd0;
      shadow_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      fi_q     <= fi_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fi_d     = fi_q;
    shadow_d = shadow_q;
    abort_s  = 1'b0;
    bit_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (fall_q) begin
          if (len_match(len_s, StartBurstSize, Tolerance)) begin
            state_d  = ST_GAP;
            fi_d     = FI_CAR_SELECT;
            shadow_d = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (sat_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_GAP: begin
        if (rise_q) begin
          if (len_match(len_s, GapSize, Tolerance)) begin
            state_d = ST_BURST;
          end else begin
            state_d = ST_IDLE;
            abort_s = 1'b1;
          end
        end else if (len_s > 8'(GapSize + Tolerance)) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_BURST: begin
        if (fall_q) begin
          if (fi_q == FI_CAR_SELECT) begin
            if (len_match(len_s, CarSelectBurstSize, Tolerance)) begin
              state_d = ST_GAP;
              fi_d    = fi_q + 3'd1;
            end else begin
              state_d = ST_IDLE;
              abort_s = 1'b1;
            end
          end else if (len_match(len_s, AsserBurstSize, Tolerance) ||
                       len_match(len_s, DeAsserBurstSize, Tolerance)) begin
            // Asserted is tested first so it wins when the two windows overlap.
            bit_s = len_match(len_s, AsserBurstSize, Tolerance);
            shadow_d[field_bit(fi_q)] = bit_s;
            if (fi_q == FI_FORWARD) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GAP;
              fi_d    = fi_q + 3'd1;
            end
          end else begin
            state_d = ST_IDLE;
            abort_s = 1'b1;
          end
        end else if (sat_s) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    command_d   = command_q;
    cmd_valid_d = 1'b0;
    pkt_err_d   = abort_s;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      command_d   = shadow_d;
      cmd_valid_d = 1'b1;
    end else begin
      command_d   = command_q;
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      command_q   <= 4'd0;
      cmd_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      command_q   <= command_d;
      cmd_valid_q <= cmd_valid_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign COMMAND   = command_q;
  assign CMD_VALID = cmd_valid_q;
  assign PKT_ERR   = pkt_err_q;
  assign STATE     = state_q;

endmodule
